// File: rtl/controle_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
// State encoding, HALT opcode and drain length live here.
package controle_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    DRAIN    = 3'd2,
    HALTED   = 3'd3,
    ERRO     = 3'd4
  } estado_t;

  localparam logic [5:0] HALT_OPCODE  = 6'b111111;
  localparam int         DRAIN_CYCLES = 3;

  // Enable vector order: PC, IFID, IDEX, EXMEM, MEMWB
  localparam logic [4:0] EN_ALL  = 5'b11111;
  localparam logic [4:0] EN_NONE = 5'b00000;
  localparam logic [4:0] EN_BUB  = 5'b00111;

endpackage

// File: rtl/controle_pipeline_contador.sv
// Saturating up-counter used for the pipeline statistics.
// Holds at all-ones instead of wrapping.
module contador_saturado #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/controle_pipeline.sv
// Central stall/flush sequencer: merges load-use, branch and memory
// handshake into pipeline enables, flushes and bubble select.
module controle_pipeline
  import controle_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             memRead_EXMEM,
  input  logic             memWrite_EXMEM,
  input  logic             mem_ack,
  input  logic             loadUse,
  input  logic             PCSrc,
  input  logic             halt_ID,
  output logic             mem_req,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             MEMWBWrite,
  output logic             flushIFID,
  output logic             flushIDEX,
  output logic             flushEXMEM,
  output logic             hazardMux,
  output logic             halted,
  output logic             erro,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int         WW     = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] W_LAST = WW'(TIMEOUT - 1);
  localparam logic [1:0] D_LAST = 2'(DRAIN_CYCLES - 1);

  estado_t       r_state;
  estado_t       r_ret;
  logic [WW-1:0] r_wait;
  logic [1:0]    r_drain;

  estado_t       w_next;
  estado_t       w_ret_next;
  logic [WW-1:0] w_wait_next;
  logic [1:0]    w_drain_next;
  logic [4:0]    w_en;
  logic          w_flush;
  logic          w_bub;
  logic          w_req;
  logic          w_halted;
  logic          w_erro;
  logic          w_acc;
  logic          w_stall;
  logic          w_active;
  logic          w_stall_inc;
  logic          w_flush_inc;

  assign w_acc   = memRead_EXMEM | memWrite_EXMEM;
  assign w_stall = w_acc & ~mem_ack;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
      r_ret   <= RUN;
      r_wait  <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_next;
      r_ret   <= w_ret_next;
      r_wait  <= w_wait_next;
      r_drain <= w_drain_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_ret_next   = r_ret;
    w_wait_next  = r_wait;
    w_drain_next = r_drain;
    w_en         = EN_ALL;
    w_flush      = 1'b0;
    w_bub        = 1'b0;
    w_req        = 1'b0;
    w_halted     = 1'b0;
    w_erro       = 1'b0;
    w_flush_inc  = 1'b0;
    case (r_state)
      RUN: begin
        w_req = w_acc;
        if (w_stall) begin
          w_en        = EN_NONE;
          w_next      = MEM_WAIT;
          w_ret_next  = RUN;
          w_wait_next = '0;
        end else if (PCSrc) begin
          w_flush     = 1'b1;
          w_flush_inc = 1'b1;
        end else if (loadUse) begin
          w_en  = EN_BUB;
          w_bub = 1'b1;
        end else if (halt_ID) begin
          w_next       = DRAIN;
          w_drain_next = '0;
        end
      end
      DRAIN: begin
        w_req = w_acc;
        if (w_stall) begin
          w_en        = EN_NONE;
          w_next      = MEM_WAIT;
          w_ret_next  = DRAIN;
          w_wait_next = '0;
        end else if (PCSrc) begin
          // halt was fetched on the wrong path
          w_flush     = 1'b1;
          w_flush_inc = 1'b1;
          w_next      = RUN;
        end else begin
          w_en  = EN_BUB;
          w_bub = 1'b1;
          if (r_drain == D_LAST) begin
            w_next = HALTED;
          end else begin
            w_drain_next = r_drain + 1'b1;
          end
        end
      end
      MEM_WAIT: begin
        w_req = w_acc;
        if (mem_ack) begin
          w_next = r_ret;
        end else begin
          w_en = EN_NONE;
          if (r_wait == W_LAST) begin
            w_next = ERRO;
          end else begin
            w_wait_next = r_wait + 1'b1;
          end
        end
      end
      HALTED: begin
        w_en     = EN_NONE;
        w_halted = 1'b1;
      end
      ERRO: begin
        w_en   = EN_NONE;
        w_erro = 1'b1;
      end
      default: begin
        w_en   = EN_NONE;
        w_next = RUN;
      end
    endcase
  end

  assign w_active = (r_state == RUN) | (r_state == DRAIN) |
                    (r_state == MEM_WAIT);
  assign w_stall_inc = w_active & ~w_en[4];

  // request is dropped as soon as reset asserts
  assign mem_req    = w_req & reset_n;
  assign PCWrite    = w_en[4];
  assign IFIDWrite  = w_en[3];
  assign IDEXWrite  = w_en[2];
  assign EXMEMWrite = w_en[1];
  assign MEMWBWrite = w_en[0];
  assign flushIFID  = w_flush;
  assign flushIDEX  = w_flush;
  assign flushEXMEM = w_flush;
  assign hazardMux  = w_bub;
  assign halted     = w_halted;
  assign erro       = w_erro;

  contador_saturado #(.W(CNT_W)) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_stall_inc),
    .count   (stall_count)
  );

  contador_saturado #(.W(CNT_W)) u_flush_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_flush_inc),
    .count   (flush_count)
  );

endmodule

// File: tb/tb_controle_pipeline.sv
// Scoreboard bench for controle_pipeline: driver pushes model
// expectations, negedge monitor pops and compares.
module tb_controle_pipeline;

  localparam int TMO  = 15;
  localparam int CW   = 4;
  localparam int SMAX = (1 << CW) - 1;

  logic clk;
  logic rst_n;
  logic rd, wr, ack, lu, br, hl;
  logic mem_req, pcw, ifw, idw, exw, mww;
  logic fif, fid, fex, hmux, hlt, err;
  logic [CW-1:0] scnt, fcnt;

  controle_pipeline #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clock          (clk),
    .reset_n        (rst_n),
    .memRead_EXMEM  (rd),
    .memWrite_EXMEM (wr),
    .mem_ack        (ack),
    .loadUse        (lu),
    .PCSrc          (br),
    .halt_ID        (hl),
    .mem_req        (mem_req),
    .PCWrite        (pcw),
    .IFIDWrite      (ifw),
    .IDEXWrite      (idw),
    .EXMEMWrite     (exw),
    .MEMWBWrite     (mww),
    .flushIFID      (fif),
    .flushIDEX      (fid),
    .flushEXMEM     (fex),
    .hazardMux      (hmux),
    .halted         (hlt),
    .erro           (err),
    .stall_count    (scnt),
    .flush_count    (fcnt)
  );

  typedef struct {
    logic [11:0] sig;
    int          sc;
    int          fc;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: pipeline situation as plain flags and counts
  bit m_wait, m_drain, m_halt, m_err;
  int m_wc, m_dc, m_stall, m_flush;

  task automatic m_clear();
    m_wait = 0; m_drain = 0; m_halt = 0; m_err = 0;
    m_wc = 0; m_dc = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model(input bit rst, output exp_t e);
    bit acc, frz, fl, bub, req, counted;
    acc = rd | wr;
    frz = 0; fl = 0; bub = 0; req = 0;
    if (rst) m_clear();
    e.sc = m_stall;
    e.fc = m_flush;
    counted = !(m_err || m_halt);
    if (m_err) begin
      frz = 1;
    end else if (m_halt) begin
      frz = 1;
    end else if (m_wait) begin
      req = acc;
      if (ack) begin
        m_wait = 0;
      end else begin
        frz = 1;
        m_wc++;
        if (m_wc == TMO) begin
          m_wait = 0;
          m_err = 1;
        end
      end
    end else begin
      req = acc;
      if (acc && !ack) begin
        frz = 1; m_wait = 1; m_wc = 0;
      end else if (br) begin
        fl = 1; m_drain = 0;
        if (m_flush < SMAX) m_flush++;
      end else if (m_drain) begin
        bub = 1; m_dc++;
        if (m_dc == 3) begin
          m_drain = 0; m_halt = 1;
        end
      end else if (lu) begin
        bub = 1;
      end else if (hl) begin
        m_drain = 1; m_dc = 0;
      end
    end
    e.sig[11] = rst ? 1'b0 : req;
    e.sig[10:6] = frz ? 5'b00000 : (bub ? 5'b00111 : 5'b11111);
    e.sig[5:3] = fl ? 3'b111 : 3'b000;
    e.sig[2] = bub;
    e.sig[1] = (e.sig[10:6] == 5'b0) && !m_wait && !m_err && m_halt
               && counted == 1'b0;
    e.sig[0] = 1'b0;
    // halted / erro flags reflect the situation at cycle start
    if (frz && !counted) begin
      e.sig[1] = 1'b0;
      e.sig[0] = 1'b0;
    end
    if (counted && !e.sig[10] && (m_stall < SMAX)) m_stall++;
    if (rst) m_clear();
  endtask

  bit p_halt, p_err;

  task automatic cyc(input bit r, w, a, l, b, h);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    rd = r; wr = w; ack = a; lu = l; br = b; hl = h;
    p_halt = m_halt; p_err = m_err;
    model(1'b0, e);
    e.sig[1] = p_halt;
    e.sig[0] = p_err;
    q.push_back(e);
  endtask

  task automatic do_reset(input bit r, a);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rd = r; wr = 0; ack = a; lu = 0; br = 0; hl = 0;
    model(1'b1, e);
    e.sig[1] = 1'b0;
    e.sig[0] = 1'b0;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    exp_t e;
    logic [11:0] got;
    if (q.size() > 0) begin
      e = q.pop_front();
      got = {mem_req, pcw, ifw, idw, exw, mww, fif, fid, fex,
             hmux, hlt, err};
      vectors++;
      if (got !== e.sig || int'(scnt) != e.sc || int'(fcnt) != e.fc) begin
        miscompares++;
        $display("FAIL cycle t=%0t outs=%b/%0d/%0d want=%b/%0d/%0d",
                 $time, got, scnt, fcnt, e.sig, e.sc, e.fc);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    rd = 0; wr = 0; ack = 0; lu = 0; br = 0; hl = 0;
    m_clear();
    do_reset(0, 0);
    idle(3);
    cyc(0, 0, 0, 1, 0, 0);
    idle(2);
    cyc(0, 0, 0, 1, 1, 0);
    idle(2);
    // load acked on 4th wait cycle, branch pending all along
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0);
    idle(2);
    // single-cycle access
    cyc(0, 1, 1, 0, 0, 0);
    idle(1);
    // reset in the middle of a wait
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    do_reset(1, 0);
    do_reset(1, 1);
    idle(2);
    // timeout
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 1, 1, 1);
    idle(2);
    do_reset(0, 0);
    // halt drain
    cyc(0, 0, 0, 0, 0, 1);
    idle(6);
    cyc(0, 0, 0, 1, 1, 0);
    do_reset(0, 0);
    // branch during second drain cycle
    cyc(0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(0, 0, 0, 0, 1, 0);
    idle(4);
    do_reset(0, 0);
    // memory stall inside drain
    cyc(0, 0, 0, 0, 0, 1);
    idle(1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 0, 0);
    idle(5);
    do_reset(0, 0);
    // counter saturation
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 1, 0);
    idle(1);
    do_reset(0, 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0);
      end else begin
        cyc($urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 20,
            $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 5);
      end
    end
    idle(1);
    repeat (3) @(posedge clk);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain queue left=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
